regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 91 +++++++++
 tb/tb_regfile_mp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with a post-reset clear sweep, same-cycle write
// bypass on reads, and a per-register pending scoreboard.
module regfile_mp #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we0,
  input  logic [AW-1:0]        wa0,
  input  logic [WIDTH-1:0]     wd0,
  input  logic                 we1,
  input  logic [AW-1:0]        wa1,
  input  logic [WIDTH-1:0]     wd1,
  input  logic [NRD*AW-1:0]    ra,
  output logic [NRD*WIDTH-1:0] rd,
  input  logic                 bset,
  input  logic [AW-1:0]        baddr,
  output logic [NRD-1:0]       rbusy,
  output logic                 ready
);

  // state | meaning
  // CLEAR | sweeping data[1..NREG-1] to zero, one per edge; file not usable
  // RUN   | sweep done, reads/writes/scoreboard active
  typedef enum logic {CLEAR, RUN} state_e;

  state_e           state_q;
  logic [AW-1:0]    cnt_q;
  logic             ready_q;
  logic [WIDTH-1:0] data_q [NREG];
  logic [NREG-1:0]  pend_q;
  logic [NREG-1:0]  pend_d;

  // Set is applied after the clears so a same-cycle bset on a written register wins.
  always_comb begin
    pend_d = pend_q;
    if (we0)  pend_d[wa0]   = 1'b0;
    if (we1)  pend_d[wa1]   = 1'b0;
    if (bset) pend_d[baddr] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= AW'(1);
      pend_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          data_q[cnt_q] <= '0;
          cnt_q         <= cnt_q + AW'(1);
          if (cnt_q == AW'(NREG - 1)) begin
            state_q <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN: begin
          pend_q <= pend_d;
          if (we0 && (wa0 != '0)) data_q[wa0] <= wd0;
          if (we1 && (wa1 != '0)) data_q[wa1] <= wd1;
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit0;
    logic          hit1;
    logic          bhit;

    assign a    = ra[k*AW +: AW];
    assign hit0 = we0 && (wa0 == a);
    assign hit1 = we1 && (wa1 == a);
    assign bhit = bset && (baddr == a);

    assign rd[k*WIDTH +: WIDTH] = (!ready_q || (a == '0)) ? '0 :
                                  hit1 ? wd1 :
                                  hit0 ? wd0 : data_q[a];
    assign rbusy[k] = ready_q && pend_q[a] && !((hit0 || hit1) && !bhit);
  end

  assign ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus random traffic
// against an array/edge-count reference model; second instance for wide params.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1, bset;
  logic [4:0]  wa0, wa1, baddr;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        ready;

  logic         rst2, we02, we12, bset2;
  logic [3:0]   wa02, wa12, baddr2;
  logic [63:0]  wd02, wd12;
  logic [15:0]  ra2;
  logic [255:0] rd2;
  logic [3:0]   rbusy2;
  logic         ready2;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk(clk), .rst(rst),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .bset(bset), .baddr(baddr),
    .rbusy(rbusy), .ready(ready)
  );

  regfile_mp #(.WIDTH(64), .NREG(16), .NRD(4)) dut2 (
    .clk(clk), .rst(rst2),
    .we0(we02), .wa0(wa02), .wd0(wd02),
    .we1(we12), .wa1(wa12), .wd1(wd12),
    .ra(ra2), .rd(rd2), .bset(bset2), .baddr(baddr2),
    .rbusy(rbusy2), .ready(ready2)
  );

  int nchk  = 0;
  int npass = 0;

  // Reference model: register contents, pending set, edges since reset released.
  logic [31:0] mdata [32];
  logic        mpend [32];
  logic        mready;
  int          medges;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass = npass + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!mready || a == 0)  return 32'h0;
    if (we1 && wa1 == a)    return wd1;
    if (we0 && wa0 == a)    return wd0;
    return mdata[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    logic wr;
    if (!mready || a == 0) return 1'b0;
    wr = (we0 && wa0 == a) || (we1 && wa1 == a);
    if (wr && !(bset && baddr == a)) return 1'b0;
    return mpend[a];
  endfunction

  task automatic model_update();
    if (rst) begin
      mready = 1'b0;
      medges = 0;
      for (int i = 0; i < 32; i++) mpend[i] = 1'b0;
    end else if (!mready) begin
      medges++;
      if (medges == 31) begin
        mready = 1'b1;
        for (int i = 0; i < 32; i++) mdata[i] = 32'h0;
      end
    end else begin
      if (we0 && wa0 != 0) mdata[wa0] = wd0;
      if (we1 && wa1 != 0) mdata[wa1] = wd1;
      if (we0) mpend[wa0] = 1'b0;
      if (we1) mpend[wa1] = 1'b0;
      if (bset && baddr != 0) mpend[baddr] = 1'b1;
    end
  endtask

  task automatic check_all();
    logic [4:0] a;
    chk("ready", 64'(ready), 64'(mready));
    for (int k = 0; k < 2; k++) begin
      a = ra[k*5 +: 5];
      chk($sformatf("rd%0d@%0d", k, a), 64'(rd[k*32 +: 32]), 64'(exp_rd(a)));
      chk($sformatf("rbusy%0d@%0d", k, a), 64'(rbusy[k]), 64'(exp_busy(a)));
    end
  endtask

  task automatic peek();
    @(negedge clk);
  endtask

  task automatic finish_cycle();
    check_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic step();
    peek();
    finish_cycle();
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; bset = 0;
    wa0 = 0; wa1 = 0; baddr = 0;
    wd0 = 0; wd1 = 0;
  endtask

  task automatic rand_inputs();
    we0   = 1'($urandom);
    we1   = 1'($urandom);
    bset  = 1'($urandom);
    wa0   = 5'($urandom_range(0, 7));
    wa1   = 5'($urandom_range(0, 7));
    baddr = 5'($urandom_range(0, 7));
    wd0   = $urandom;
    wd1   = $urandom;
    ra    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
  endtask

  task automatic sweep_until_ready(input string tag, input bit randomize_in);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      if (randomize_in) rand_inputs();
      step();
      n++;
    end
    chk(tag, 64'(n), 64'd31);
  endtask

  initial begin
    logic [63:0] d2 [4];
    logic [3:0]  a2 [4];
    int          n;

    mready = 1'b0;
    medges = 0;
    for (int i = 0; i < 32; i++) begin
      mpend[i] = 1'b0;
      mdata[i] = 32'h0;
    end
    rst = 1; idle(); ra = 0;

    // Wide instance: sweep length, reads during sweep, four distinct read ports.
    rst2 = 1; we02 = 0; we12 = 0; bset2 = 0; wa02 = 0; wa12 = 0; baddr2 = 0;
    wd02 = 0; wd12 = 0; ra2 = 16'h3210;
    @(posedge clk); #1;
    chk("w_ready_rst", 64'(ready2), 64'd0);
    chk("w_rbusy_rst", 64'(rbusy2), 64'd0);
    rst2 = 0;
    n = 0;
    while (!ready2 && n < 100) begin
      chk("w_rd_sweep", rd2[63:0] | rd2[127:64] | rd2[191:128] | rd2[255:192], 64'd0);
      @(posedge clk); #1;
      n++;
    end
    chk("w_sweep_len", 64'(n), 64'd15);
    a2[0] = 4'd3; a2[1] = 4'd6; a2[2] = 4'd9; a2[3] = 4'd14;
    for (int i = 0; i < 4; i++) d2[i] = {$urandom, $urandom};
    we02 = 1; wa02 = a2[0]; wd02 = d2[0]; we12 = 1; wa12 = a2[1]; wd12 = d2[1];
    @(posedge clk); #1;
    wa02 = a2[2]; wd02 = d2[2]; wa12 = a2[3]; wd12 = d2[3];
    @(posedge clk); #1;
    we02 = 0; we12 = 0;
    ra2 = {a2[3], a2[2], a2[1], a2[0]};
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("w_rd%0d", k), rd2[k*64 +: 64], d2[k]);
    chk("w_rbusy", 64'(rbusy2), 64'd0);

    // Main instance: reset then sweep, with junk inputs that must be ignored.
    rst = 1; step();
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_rd", rd, 64'd0);
    rst = 0;
    sweep_until_ready("sweep_len", 1'b1);
    idle();
    for (int a = 0; a < 32; a += 2) begin
      ra = {5'(a + 1), 5'(a)};
      peek();
      chk("zero_after_sweep", rd, 64'd0);
      finish_cycle();
    end

    // Write with same-cycle bypass.
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; ra = {5'd5, 5'd5};
    peek(); chk("bypass_same", 64'(rd[31:0]), 64'hDEADBEEF); finish_cycle();
    we0 = 0;
    peek(); chk("bypass_after", 64'(rd[31:0]), 64'hDEADBEEF); finish_cycle();

    // Collision on one address.
    we0 = 1; wa0 = 7; wd0 = 32'h11; we1 = 1; wa1 = 7; wd1 = 32'h22; ra = {5'd7, 5'd7};
    peek(); chk("coll_same", 64'(rd[31:0]), 64'h22); finish_cycle();
    idle();
    peek(); chk("coll_after", 64'(rd[63:32]), 64'h22); finish_cycle();

    // Register zero.
    we1 = 1; wa1 = 0; wd1 = 32'hFFFF_FFFF; bset = 1; baddr = 0; ra = {5'd0, 5'd0};
    peek(); chk("r0_rd", rd, 64'd0); chk("r0_busy", 64'(rbusy), 64'd0); finish_cycle();
    idle();
    peek(); chk("r0_rd_after", rd, 64'd0); chk("r0_busy_after", 64'(rbusy), 64'd0); finish_cycle();

    // Scoreboard set then cleared by a write.
    bset = 1; baddr = 3; ra = {5'd3, 5'd3};
    step();
    idle();
    peek(); chk("sb_set", 64'(rbusy), 64'd3); finish_cycle();
    we0 = 1; wa0 = 3; wd0 = 32'h1234;
    peek(); chk("sb_clr_same", 64'(rbusy), 64'd0); finish_cycle();
    idle();
    peek(); chk("sb_clr_after", 64'(rbusy), 64'd0); finish_cycle();

    // Set wins over a same-cycle write.
    bset = 1; baddr = 3; we1 = 1; wa1 = 3; wd1 = 32'hABCD;
    step();
    idle();
    peek();
    chk("setwin_data", 64'(rd[31:0]), 64'hABCD);
    chk("setwin_busy", 64'(rbusy), 64'd3);
    finish_cycle();

    // Mid-sweep reset clears pending and restarts the 31-edge sweep.
    bset = 1; baddr = 9; step(); idle();
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 9; i++) step();
    rst = 1; step(); rst = 0;
    sweep_until_ready("midsweep_len", 1'b0);
    ra = {5'd9, 5'd3};
    peek(); chk("midsweep_pend", 64'(rbusy), 64'd0); finish_cycle();

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 0; idle();
    step();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
